alu_exec_unit: RTL and testbench

// Execute-stage ALU that consumes the 4-bit ALUCtrl code from the ALU control decoder plus two operands.

---
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Logic ops and compares finish in one cycle; shifts move one bit per cycle.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic             busy
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [3:0]         code_q, code_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;

   logic [SHAMT_W-1:0] shamt;
   logic               is_shift;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ill;
   logic [WIDTH-1:0]   acc_step;

   // One-bit shift step; SRA keeps the sign bit, which is op_a's MSB at every step.
   function automatic logic [WIDTH-1:0] shift1(input logic [3:0] code, input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (code)
         OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
         default: r = {v[WIDTH-1], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   assign shamt    = op_b[SHAMT_W-1:0];
   assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
   assign acc_step = shift1(code_q, acc_q);

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (alu_ctrl)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD:  alu_res = op_a + op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_SLL, OP_SRL, OP_SRA:
            alu_res = (shamt == '0) ? op_a : shift1(alu_ctrl, op_a);
         default: begin
            alu_res = '0;
            alu_ill = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_shift && (shamt > SHAMT_W'(1))) begin
                  acc_d   = shift1(alu_ctrl, op_a);
                  cnt_d   = shamt - SHAMT_W'(1);
                  code_d  = alu_ctrl;
                  state_d = S_SHIFT;
               end else begin
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  illegal_d = alu_ill;
                  state_d   = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            acc_d = acc_step;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d  = acc_step;
               zero_d    = (acc_step == '0);
               illegal_d = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         code_q    <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] op_a, op_b;
   logic         in_ready, out_valid, zero, illegal, busy;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
      .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic ill, output int lat);
      int sh;
      sh  = int'(b[4:0]);
      ill = 1'b0;
      lat = 1;
      case (c)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a + b;
         4'd3: r = a ^ b;
         4'd4: begin r = a << sh; lat = (sh == 0) ? 1 : sh; end
         4'd5: begin r = a >> sh; lat = (sh == 0) ? 1 : sh; end
         4'd6: r = a - b;
         4'd7: begin r = $unsigned($signed(a) >>> sh); lat = (sh == 0) ? 1 : sh; end
         4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9: r = (a < b) ? 32'd1 : 32'd0;
         default: begin r = '0; ill = 1'b1; end
      endcase
   endfunction

   // Issue one op, wait for its result, hold out_ready low for `hold` cycles, then drain.
   task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      logic [W-1:0] er;
      logic         eill, bad;
      int           elat, n;
      model(c, a, b, er, eill, elat);
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b0;
      @(posedge clk);
      n = 0; bad = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (!busy || in_ready) bad = 1'b1;
         in_valid = 1'(($urandom)); alu_ctrl = 4'($urandom);
         op_a = $urandom; op_b = $urandom; out_ready = 1'(($urandom));
         if (!out_valid) out_ready = 1'(($urandom));
      end while (!out_valid && n < 100);
      out_ready = 1'b0;
      chk({tag, "_busy"}, bad, 0);
      chk({tag, "_lat"}, n, elat);
      chk({tag, "_res"}, result, er);
      chk({tag, "_zero"}, zero, (er == '0));
      chk({tag, "_ill"}, illegal, eill);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {out_valid, in_ready, zero, result}, {1'b1, 1'b0, (er == '0), er});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drain"}, {out_valid, in_ready, busy}, 3'b010);
   endtask

   task automatic accept_shift(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      logic seen;
      logic [3:0] c;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_ctrl = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", {out_valid, result, zero, illegal, busy, in_ready}, {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
      rst = 1'b0;

      run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
      run_op("sub_hold", 4'b0110, 32'd5, 32'd5, 3);
      run_op("sra4", 4'b0111, 32'h8000_0000, 32'd4, 0);
      run_op("slt", 4'b1000, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("sltu", 4'b1001, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("sll0", 4'b0100, 32'hDEAD_BEEF, 32'h20, 0);
      run_op("srl1", 4'b0101, 32'h8000_0001, 32'd1, 1);
      run_op("ill", 4'b1111, 32'h1234, 32'h5678, 1);
      run_op("post_ill", 4'b0001, 32'h00F0, 32'h0F00, 0);
      run_op("sll31", 4'b0100, 32'h0000_0003, 32'd31, 0);

      // flush mid-shift: nothing may ever come out
      accept_shift(4'b0100, 32'h1, 32'd31);
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", {busy, in_ready, out_valid}, 3'b010);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      chk("flush_quiet", seen, 0);

      // flush wins over accept in IDLE
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd2; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_vs_accept", {busy, out_valid}, 2'b00);

      // flush wins over output handshake in DONE
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = 4'b0011; op_a = 32'hF; op_b = 32'h3;
      @(negedge clk);
      in_valid = 1'b0;
      chk("done_reached", out_valid, 1);
      flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b0;
      chk("flush_done", {out_valid, in_ready}, 2'b01);

      // reset mid-shift after a nonzero result has been held
      run_op("pre_rst", 4'b0111, 32'h8000_0000, 32'd4, 0);
      accept_shift(4'b0101, 32'hFFFF_0000, 32'd20);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid", {out_valid, result, zero, illegal, busy, in_ready}, {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});

      for (int i = 0; i < 150; i++) begin
         c = 4'($urandom_range(0, 11));
         if (c > 4'd9) c = 4'($urandom_range(10, 15));
         run_op($sformatf("rnd%0d", i), c, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
